// File: rtl/rr_arb_mux_pkg.sv
// Shared constants for the arbitrating multiplexer: arbitration mode encodings
// and the default datapath width.
package rr_arb_mux_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int XLEN      = 32;
endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Request arbiter: round-robin from a rotating pointer, or fixed lowest-index
// priority. Grant is combinational; only the pointer is stateful.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = ARB_RR,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              advance_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [CH_W-1:0]   grant_idx_o
);

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            found;
  int              base, c;

  // Scan upward from the search base, wrapping at NUM_CH (handles non-pow2 counts).
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    c           = 0;
    base        = (RR_MODE == ARB_RR) ? int'(ptr_q) : 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = base + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && req_i[c]) begin
        found       = 1'b1;
        grant_o[c]  = 1'b1;
        grant_idx_o = CH_W'(c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (RR_MODE == ARB_RR && advance_i) begin
      if (grant_idx_o == CH_W'(NUM_CH - 1)) ptr_d = '0;
      else                                  ptr_d = grant_idx_o + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer with a single registered output stage and
// valid/ready handshakes; sustains one word per cycle when downstream is ready.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH   = XLEN,
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = ARB_RR,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch
);

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gidx;
  logic              can_accept, xfer;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q, sel_data;
  logic [CH_W-1:0]   out_ch_q;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE),
    .CH_W    (CH_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (in_valid),
    .advance_i   (xfer),
    .grant_o     (grant),
    .grant_idx_o (gidx)
  );

  // rst_n gates in_ready so nothing is offered upstream while held in reset.
  assign can_accept = rst_n && (!out_valid_q || out_ready);
  assign in_ready   = can_accept ? grant : '0;
  assign xfer       = |(in_valid & in_ready);
  assign sel_data   = in_data[int'(gidx)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_ch_q    <= gidx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: 4-ch round-robin, 4-ch fixed priority and 3-ch round-robin
// instances, each checked against hand-computed expectations.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // d0: 4-ch round-robin
  logic [3:0]    v0, r0;
  logic [127:0]  d0;
  logic          ov0, or0;
  logic [31:0]   od0;
  logic [1:0]    oc0;
  // d1: 4-ch fixed priority
  logic [3:0]    v1, r1;
  logic [127:0]  d1;
  logic          ov1, or1;
  logic [31:0]   od1;
  logic [1:0]    oc1;
  // d2: 3-ch round-robin
  logic [2:0]    v2, r2;
  logic [95:0]   d2;
  logic          ov2, or2;
  logic [31:0]   od2;
  logic [1:0]    oc2;

  rr_arb_mux #(.WIDTH(32), .NUM_CH(4), .RR_MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ch(oc0));

  rr_arb_mux #(.WIDTH(32), .NUM_CH(4), .RR_MODE(0)) u_fix4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ch(oc1));

  rr_arb_mux #(.WIDTH(32), .NUM_CH(3), .RR_MODE(1)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_data(d2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_ch(oc2));

  initial begin
    rst_n = 1'b0;
    v0 = 4'hF; or0 = 1'b1;
    for (int i = 0; i < 4; i++) d0[i*32 +: 32] = 32'hA0 + i;
    v1 = '0; or1 = 1'b0; d1 = '0;
    v2 = '0; or2 = 1'b0;
    for (int i = 0; i < 3; i++) d2[i*32 +: 32] = 32'hB0 + i;

    // Reset held with all channels requesting
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(ov0), 32'd0);
    chk("rst_data",  od0,      32'd0);
    chk("rst_ch",    32'(oc0), 32'd0);
    chk("rst_ready", 32'(r0),  32'd0);
    rst_n = 1'b1;

    // Rotation 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rot_valid", 32'(ov0), 32'd1);
      chk("rot_ch",    32'(oc0), 32'(i % 4));
      chk("rot_data",  od0,      32'hA0 + 32'(i % 4));
    end

    // Load 0xDEADBEEF from ch2 (pointer at 1, only ch2 requesting)
    v0 = 4'b0100; d0[64 +: 32] = 32'hDEADBEEF;
    @(negedge clk);
    chk("bp_load_ch",   32'(oc0), 32'd2);
    chk("bp_load_data", od0,      32'hDEADBEEF);
    or0 = 1'b0; v0 = 4'hF;
    #1 chk("bp_ready0", 32'(r0), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov0), 32'd1);
      chk("bp_data",  od0,      32'hDEADBEEF);
      chk("bp_ch",    32'(oc0), 32'd2);
      chk("bp_ready", 32'(r0),  32'd0);
    end
    // Release: pointer is 3, so ch3 refills in the drain cycle
    or0 = 1'b1;
    #1 chk("bp_release_ready", 32'(r0), 32'b1000);
    @(negedge clk);
    chk("refill_valid", 32'(ov0), 32'd1);
    chk("refill_ch",    32'(oc0), 32'd3);
    chk("refill_data",  od0,      32'hA3);

    // Drain to empty; data/ch hold
    v0 = 4'b0000;
    @(negedge clk);
    chk("drain_valid", 32'(ov0), 32'd0);
    chk("drain_ch",    32'(oc0), 32'd3);
    chk("drain_data",  od0,      32'hA3);
    // Pointer wrapped to 0: ch0 beats ch1
    v0 = 4'b0011;
    #1 chk("wrap_ready", 32'(r0), 32'b0001);
    @(negedge clk);
    chk("wrap_valid", 32'(ov0), 32'd1);
    chk("wrap_ch",    32'(oc0), 32'd0);
    chk("wrap_data",  od0,      32'hA0);

    // Async reset between edges while holding a word
    v0 = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ov0), 32'd0);
    chk("arst_data",  od0,      32'd0);
    chk("arst_ready", 32'(r0),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_restart_ch",    32'(oc0), 32'd0);
    chk("arst_restart_valid", 32'(ov0), 32'd1);
    @(negedge clk);
    chk("arst_next_ch", 32'(oc0), 32'd1);
    v0 = '0;

    // Fixed priority: ch1 always wins over ch3
    d1[32 +: 32] = 32'h11; d1[96 +: 32] = 32'h33;
    v1 = 4'b1010; or1 = 1'b1;
    #1 chk("fix_ready0", 32'(r1), 32'b0010);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fix_ch",    32'(oc1), 32'd1);
      chk("fix_data",  od1,      32'h11);
      chk("fix_ready", 32'(r1),  32'b0010);
    end
    v1 = '0;

    // 3-channel rotation with wrap 2 -> 0
    v2 = 3'b111; or2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr3_ch",   32'(oc2), 32'(i % 3));
      chk("rr3_data", od2,      32'hB0 + 32'(i % 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
